// File: rtl/contador_ocupacion_pkg.sv
// contador_ocupacion_pkg
// Shared constants and types for the parking occupancy counter.
//   CAPACIDAD_DEF / W_DEF : default capacity and count width.
//   upd_e                 : kind of update applied in a cycle (also used
//                           by the display controller).
//   clasificar()          : maps the detected edges and current flags to upd_e.
package contador_ocupacion_pkg;

  localparam int CAPACIDAD_DEF = 99;
  localparam int W_DEF         = 7;

  typedef enum logic [2:0] {
    NADA    = 3'd0,
    INC     = 3'd1,
    DEC     = 3'd2,
    ERR_INC = 3'd3,
    ERR_DEC = 3'd4
  } upd_e;

  // Simultaneous entry and exit cancel out; the registered flags stand in
  // for the count comparisons because they always track cuenta.
  function automatic upd_e clasificar(input logic inc, input logic dec,
                                      input logic lleno, input logic vacio);
    if (inc && !dec)      return lleno ? ERR_INC : INC;
    else if (dec && !inc) return vacio ? ERR_DEC : DEC;
    else                  return NADA;
  endfunction

endpackage

// File: rtl/contador_ocupacion_detector_flanco.sv
// detector_flanco
// Single-bit rising-edge detector, synchronous active-low reset.
//   clk    : clock
//   rst    : synchronous reset, active low
//   d      : input level
//   flanco : high in the cycle d is high and was low on the previous edge
// The delay register clears on reset, so a level already high when reset
// releases is reported as one edge.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic flanco
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign flanco = d & ~d_q;

endmodule

// File: rtl/contador_ocupacion.sv
// contador_ocupacion
// Saturating vehicle occupancy counter with full/empty/sticky-error flags.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   sumar    : vehicle-in pulse (rising edge counted)
//   restar   : vehicle-out pulse (rising edge counted)
//   err_clr  : clears the sticky error flag (a new violation wins)
//   cuenta   : occupancy 0..CAPACIDAD
//   lleno    : cuenta == CAPACIDAD
//   vacio    : cuenta == 0
//   error    : sticky, increment at full or decrement at empty
//   bcd_dec, bcd_uni : tens/units digits of cuenta, only when the macro
//                      CONTADOR_BCD_EN is defined
// Parameters: CAPACIDAD in 1..99, W with 2**W > CAPACIDAD.
module contador_ocupacion
  import contador_ocupacion_pkg::*;
#(
  parameter int CAPACIDAD = CAPACIDAD_DEF,
  parameter int W         = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sumar,
  input  logic         restar,
  input  logic         err_clr,
  output logic [W-1:0] cuenta,
  output logic         lleno,
  output logic         vacio,
  output logic         error
`ifdef CONTADOR_BCD_EN
  ,
  output logic [3:0]   bcd_dec,
  output logic [3:0]   bcd_uni
`endif
);

  localparam logic [W-1:0] CAP_W = W'(CAPACIDAD);

  logic inc, dec;

  detector_flanco u_det_sumar (
    .clk    (clk),
    .rst    (rst),
    .d      (sumar),
    .flanco (inc)
  );

  detector_flanco u_det_restar (
    .clk    (clk),
    .rst    (rst),
    .d      (restar),
    .flanco (dec)
  );

  upd_e         kind;
  logic [W-1:0] cuenta_nxt;

  always_comb begin
    kind       = clasificar(inc, dec, lleno, vacio);
    cuenta_nxt = cuenta;
    case (kind)
      INC:     cuenta_nxt = cuenta + W'(1);
      DEC:     cuenta_nxt = cuenta - W'(1);
      default: cuenta_nxt = cuenta;
    endcase
  end

  // Flags are derived from cuenta_nxt so they land in the same cycle as
  // the count they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cuenta <= '0;
      lleno  <= 1'b0;
      vacio  <= 1'b1;
      error  <= 1'b0;
    end else begin
      cuenta <= cuenta_nxt;
      lleno  <= (cuenta_nxt == CAP_W);
      vacio  <= (cuenta_nxt == '0);
      if (kind == ERR_INC || kind == ERR_DEC) error <= 1'b1;
      else if (err_clr)                       error <= 1'b0;
    end
  end

`ifdef CONTADOR_BCD_EN
  // Decimal digits kept in lockstep with cuenta; CAPACIDAD <= 99 keeps the
  // tens digit within 0..9.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_dec <= 4'd0;
      bcd_uni <= 4'd0;
    end else begin
      case (kind)
        INC: begin
          if (bcd_uni == 4'd9) begin
            bcd_uni <= 4'd0;
            bcd_dec <= bcd_dec + 4'd1;
          end else begin
            bcd_uni <= bcd_uni + 4'd1;
          end
        end
        DEC: begin
          if (bcd_uni == 4'd0) begin
            bcd_uni <= 4'd9;
            bcd_dec <= bcd_dec - 4'd1;
          end else begin
            bcd_uni <= bcd_uni - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_contador_ocupacion.sv
// tb_contador_ocupacion
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor on the falling edge pops and compares against the DUT.
// Uses CAPACIDAD=12 so saturation, the 9->10 decimal carry and the
// mid-operation reset are all reachable in a short run.
module tb_contador_ocupacion;

  localparam int CAP = 12;
  localparam int WW  = 4;

  logic          clk;
  logic          rst;
  logic          sumar, restar, err_clr;
  logic [WW-1:0] cuenta;
  logic          lleno, vacio, error;
`ifdef CONTADOR_BCD_EN
  logic [3:0]    bcd_dec, bcd_uni;
`endif

  contador_ocupacion #(.CAPACIDAD(CAP), .W(WW)) dut (
    .clk     (clk),
    .rst     (rst),
    .sumar   (sumar),
    .restar  (restar),
    .err_clr (err_clr),
    .cuenta  (cuenta),
    .lleno   (lleno),
    .vacio   (vacio),
    .error   (error)
`ifdef CONTADOR_BCD_EN
    ,
    .bcd_dec (bcd_dec),
    .bcd_uni (bcd_uni)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         nombre;
    logic [WW-1:0] c;
    logic          l;
    logic          v;
    logic          e;
    logic [7:0]    bcd;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: outputs are stable between edges, so sample on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      logic bad;
      x   = sb.pop_front();
      bad = (cuenta !== x.c) || (lleno !== x.l) || (vacio !== x.v) || (error !== x.e);
`ifdef CONTADOR_BCD_EN
      bad = bad || ({bcd_dec, bcd_uni} !== x.bcd);
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got cuenta=%0d lleno=%b vacio=%b error=%b, want cuenta=%0d lleno=%b vacio=%b error=%b bcd=%h",
                 x.nombre, cuenta, lleno, vacio, error, x.c, x.l, x.v, x.e, x.bcd);
`ifdef CONTADOR_BCD_EN
        $display("  bcd got %h%h", bcd_dec, bcd_uni);
`endif
      end
    end
  end

  task automatic chk(input string n, input int c, input logic l, input logic v,
                     input logic e, input logic [7:0] bcd);
    exp_t x;
    x.nombre = n; x.c = WW'(c); x.l = l; x.v = v; x.e = e; x.bcd = bcd;
    sb.push_back(x);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL %s: monitor did not consume expectation within 5 cycles", n);
      vectors++;
      miscompares++;
      sb.delete();
    end
  endtask

  // One-cycle pulse on the selected inputs, then one idle cycle.
  task automatic pulso(input logic s, input logic r, input logic c);
    @(negedge clk); sumar = s; restar = r; err_clr = c;
    @(negedge clk); sumar = 1'b0; restar = 1'b0; err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sumar = 1'b0; restar = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset", 0, 1'b0, 1'b1, 1'b0, 8'h00);

    pulso(1, 0, 0);
    chk("first_inc", 1, 0, 0, 0, 8'h01);
    repeat (2) pulso(1, 0, 0);
    chk("three_inc", 3, 0, 0, 0, 8'h03);

    @(negedge clk); sumar = 1'b1;
    repeat (10) @(negedge clk);
    sumar = 1'b0;
    @(negedge clk);
    chk("held_level", 4, 0, 0, 0, 8'h04);

    pulso(1, 0, 0);
    pulso(1, 1, 0);
    chk("inc_dec_same", 5, 0, 0, 0, 8'h05);

    repeat (4) pulso(1, 0, 0);
    chk("count_9", 9, 0, 0, 0, 8'h09);
    pulso(1, 0, 0);
    chk("carry_10", 10, 0, 0, 0, 8'h10);
    pulso(0, 1, 0);
    chk("borrow_9", 9, 0, 0, 0, 8'h09);

    repeat (3) pulso(1, 0, 0);
    chk("full", 12, 1, 0, 0, 8'h12);
    pulso(1, 0, 0);
    chk("inc_at_full", 12, 1, 0, 1, 8'h12);
    pulso(0, 0, 1);
    chk("err_clr", 12, 1, 0, 0, 8'h12);
    pulso(1, 0, 1);
    chk("set_wins_full", 12, 1, 0, 1, 8'h12);

    repeat (5) pulso(0, 1, 0);
    chk("down_to_7", 7, 0, 0, 1, 8'h07);

    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", 0, 0, 1, 0, 8'h00);

    // Input already high while reset releases counts once.
    @(negedge clk); rst = 1'b0; sumar = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); sumar = 1'b0;
    @(negedge clk);
    chk("high_at_release", 1, 0, 0, 0, 8'h01);

    pulso(0, 1, 0);
    chk("back_to_empty", 0, 0, 1, 0, 8'h00);
    pulso(0, 1, 0);
    chk("dec_at_empty", 0, 0, 1, 1, 8'h00);
    pulso(0, 1, 1);
    chk("set_wins_empty", 0, 0, 1, 1, 8'h00);
    pulso(0, 0, 1);
    chk("final_clr", 0, 0, 1, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
